// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default widths, INP_VALID encodings and command enums.
// Multiply commands are only decoded when ALU_MULT_EN is defined.
package alu_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CMD_W  = 4;

    // INP_VALID: bit0 flags OPA, bit1 flags OPB.
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    typedef enum logic [3:0] {
        ARITH_ADD     = 4'd0,
        ARITH_SUB     = 4'd1,
        ARITH_ADD_CIN = 4'd2,
        ARITH_SUB_CIN = 4'd3,
        ARITH_INC_A   = 4'd4,
        ARITH_DEC_A   = 4'd5,
        ARITH_INC_B   = 4'd6,
        ARITH_DEC_B   = 4'd7,
        ARITH_CMP     = 4'd8,
        ARITH_MUL_INC = 4'd9,
        ARITH_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        LOGIC_AND   = 4'd0,
        LOGIC_NAND  = 4'd1,
        LOGIC_OR    = 4'd2,
        LOGIC_NOR   = 4'd3,
        LOGIC_XOR   = 4'd4,
        LOGIC_XNOR  = 4'd5,
        LOGIC_NOT_A = 4'd6,
        LOGIC_NOT_B = 4'd7,
        LOGIC_SHR_A = 4'd8,
        LOGIC_SHL_A = 4'd9,
        LOGIC_SHR_B = 4'd10,
        LOGIC_SHL_B = 4'd11,
        LOGIC_ROL   = 4'd12,
        LOGIC_ROR   = 4'd13
    } logic_cmd_e;

    function automatic logic operands_present(input logic [1:0] iv, input logic [1:0] need);
        return (iv & need) == need;
    endfunction

endpackage

// File: rtl/alu_mult.sv
// Two-stage unsigned multiplier for the MODE=1 multiply commands: stage one latches the
// prepared factors, stage two presents their truncated product. Used only with ALU_MULT_EN.
import alu_pkg::*;

module alu_mult #(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  start_i,
    input  logic                  sel_i,
    input  logic [DATA_W-1:0]     opa_i,
    input  logic [DATA_W-1:0]     opb_i,
    output logic                  busy_o,
    output logic [2*DATA_W-1:0]   prod_o
);

    logic [DATA_W:0] fa_q, fa_d;
    logic [DATA_W:0] fb_q, fb_d;
    logic            busy_q;

    // sel_i=0: (A+1)*(B+1); sel_i=1: (A<<1 kept to DATA_W bits)*B.
    always_comb begin
        if (sel_i) begin
            fa_d = {1'b0, opa_i << 1};
            fb_d = {1'b0, opb_i};
        end else begin
            fa_d = {1'b0, opa_i} + (DATA_W+1)'(1);
            fb_d = {1'b0, opb_i} + (DATA_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            fa_q   <= '0;
            fb_q   <= '0;
        end else if (ce_i) begin
            busy_q <= start_i;
            if (start_i) begin
                fa_q <= fa_d;
                fb_q <= fb_d;
            end
        end
    end

    assign busy_o = busy_q;
    assign prod_o = {{(DATA_W-1){1'b0}}, fa_q} * {{(DATA_W-1){1'b0}}, fb_q};

endmodule

// File: rtl/alu_core.sv
// Registered arithmetic/logical ALU with operand-valid checking and clock enable.
// Define ALU_MULT_EN to build the two-cycle multiply commands (CMD 9/10 in MODE=1).
import alu_pkg::*;

module alu_core #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CMD_W  = DEFAULT_CMD_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          INP_VALID,
    input  logic                MODE,
    input  logic [CMD_W-1:0]    CMD,
    input  logic                CE,
    input  logic [DATA_W-1:0]   OPA,
    input  logic [DATA_W-1:0]   OPB,
    input  logic                CIN,
    output logic [2*DATA_W:0]   RES,
    output logic                COUT,
    output logic                OFLOW,
    output logic                G,
    output logic                E,
    output logic                L,
    output logic                ERR
);

    localparam int RES_W = 2*DATA_W + 1;

    logic [RES_W-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             oflow_q, oflow_d;
    logic             g_q, g_d;
    logic             e_q, e_d;
    logic             l_q, l_d;
    logic             err_q, err_d;

    logic [3:0]       cmd_lo;
    logic [CMD_W-1:0] cmd_hi;
    logic             cmd_ext;

    logic [DATA_W:0]   a_x, b_x, cin_x, one_x;
    logic [2:0]        rot_amt;
    logic [DATA_W-1:0] rol_v, ror_v, opb_hi;
    logic              rot_bad;

    logic [DATA_W:0] r_res;
    logic            r_cout, r_oflow, r_g, r_e, r_l;
    logic [1:0]      need;
    logic            defined, is_mult, operands_ok;

`ifdef ALU_MULT_EN
    logic                mult_start, mult_sel, mult_busy;
    logic [2*DATA_W-1:0] mult_prod;

    alu_mult #(.DATA_W(DATA_W)) u_mult (
        .clk_i   (CLK),
        .rst_i   (RST),
        .ce_i    (CE),
        .start_i (mult_start),
        .sel_i   (mult_sel),
        .opa_i   (OPA),
        .opb_i   (OPB),
        .busy_o  (mult_busy),
        .prod_o  (mult_prod)
    );
`endif

    // Command bits above the 4-bit opcode space make any command undefined.
    assign cmd_lo  = CMD[3:0];
    assign cmd_hi  = CMD >> 4;
    assign cmd_ext = |cmd_hi;

    assign a_x   = {1'b0, OPA};
    assign b_x   = {1'b0, OPB};
    assign cin_x = {{DATA_W{1'b0}}, CIN};
    assign one_x = (DATA_W+1)'(1);

    assign rot_amt = OPB[2:0];
    assign rol_v   = (OPA << rot_amt) | (OPA >> (DATA_W - rot_amt));
    assign ror_v   = (OPA >> rot_amt) | (OPA << (DATA_W - rot_amt));
    assign opb_hi  = OPB >> 4;
    assign rot_bad = |opb_hi;

    // Decode: candidate result, flags and the operands the command needs.
    always_comb begin
        r_res   = '0;
        r_cout  = 1'b0;
        r_oflow = 1'b0;
        r_g     = 1'b0;
        r_e     = 1'b0;
        r_l     = 1'b0;
        need    = IV_AB;
        defined = 1'b1;
        is_mult = 1'b0;
`ifdef ALU_MULT_EN
        mult_sel = 1'b0;
`endif
        if (cmd_ext) begin
            defined = 1'b0;
        end else if (MODE) begin
            case (cmd_lo)
                ARITH_ADD: begin
                    r_res  = a_x + b_x;
                    r_cout = r_res[DATA_W];
                end
                ARITH_SUB: begin
                    r_res   = a_x - b_x;
                    r_oflow = (a_x < b_x);
                end
                ARITH_ADD_CIN: begin
                    r_res  = a_x + b_x + cin_x;
                    r_cout = r_res[DATA_W];
                end
                ARITH_SUB_CIN: begin
                    r_res   = a_x - b_x - cin_x;
                    r_oflow = (a_x < (b_x + cin_x));
                end
                ARITH_INC_A: begin
                    need   = IV_A;
                    r_res  = a_x + one_x;
                    r_cout = r_res[DATA_W];
                end
                ARITH_DEC_A: begin
                    need    = IV_A;
                    r_res   = a_x - one_x;
                    r_oflow = (OPA == '0);
                end
                ARITH_INC_B: begin
                    need   = IV_B;
                    r_res  = b_x + one_x;
                    r_cout = r_res[DATA_W];
                end
                ARITH_DEC_B: begin
                    need    = IV_B;
                    r_res   = b_x - one_x;
                    r_oflow = (OPB == '0);
                end
                ARITH_CMP: begin
                    r_g = (OPA > OPB);
                    r_e = (OPA == OPB);
                    r_l = (OPA < OPB);
                end
`ifdef ALU_MULT_EN
                ARITH_MUL_INC: begin
                    is_mult  = 1'b1;
                    mult_sel = 1'b0;
                end
                ARITH_MUL_SHL: begin
                    is_mult  = 1'b1;
                    mult_sel = 1'b1;
                end
`endif
                default: defined = 1'b0;
            endcase
        end else begin
            case (cmd_lo)
                LOGIC_AND:   r_res = {1'b0, OPA & OPB};
                LOGIC_NAND:  r_res = {1'b0, ~(OPA & OPB)};
                LOGIC_OR:    r_res = {1'b0, OPA | OPB};
                LOGIC_NOR:   r_res = {1'b0, ~(OPA | OPB)};
                LOGIC_XOR:   r_res = {1'b0, OPA ^ OPB};
                LOGIC_XNOR:  r_res = {1'b0, ~(OPA ^ OPB)};
                LOGIC_NOT_A: begin
                    need  = IV_A;
                    r_res = {1'b0, ~OPA};
                end
                LOGIC_NOT_B: begin
                    need  = IV_B;
                    r_res = {1'b0, ~OPB};
                end
                LOGIC_SHR_A: begin
                    need  = IV_A;
                    r_res = {1'b0, OPA >> 1};
                end
                LOGIC_SHL_A: begin
                    need  = IV_A;
                    r_res = {1'b0, OPA << 1};
                end
                LOGIC_SHR_B: begin
                    need  = IV_B;
                    r_res = {1'b0, OPB >> 1};
                end
                LOGIC_SHL_B: begin
                    need  = IV_B;
                    r_res = {1'b0, OPB << 1};
                end
                LOGIC_ROL: begin
                    r_res = {1'b0, rol_v};
                    if (rot_bad) defined = 1'b0;
                end
                LOGIC_ROR: begin
                    r_res = {1'b0, ror_v};
                    if (rot_bad) defined = 1'b0;
                end
                default: defined = 1'b0;
            endcase
        end
        operands_ok = operands_present(INP_VALID, need);
    end

    // Next state: a finishing multiply owns the cycle; INP_VALID=00 leaves outputs alone.
    always_comb begin
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        err_d   = err_q;
`ifdef ALU_MULT_EN
        mult_start = 1'b0;
        if (mult_busy) begin
            res_d   = {1'b0, mult_prod};
            cout_d  = 1'b0;
            oflow_d = 1'b0;
            g_d     = 1'b0;
            e_d     = 1'b0;
            l_d     = 1'b0;
            err_d   = 1'b0;
        end else
`endif
        if (INP_VALID != IV_NONE) begin
            if (!defined || !operands_ok) begin
                res_d   = '0;
                cout_d  = 1'b0;
                oflow_d = 1'b0;
                g_d     = 1'b0;
                e_d     = 1'b0;
                l_d     = 1'b0;
                err_d   = 1'b1;
            end else if (is_mult) begin
`ifdef ALU_MULT_EN
                mult_start = 1'b1;
`endif
            end else begin
                res_d   = {{DATA_W{1'b0}}, r_res};
                cout_d  = r_cout;
                oflow_d = r_oflow;
                g_d     = r_g;
                e_d     = r_e;
                l_d     = r_l;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            err_q   <= 1'b0;
        end else if (CE) begin
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            err_q   <= err_d;
        end
    end

    assign RES   = res_q;
    assign COUT  = cout_q;
    assign OFLOW = oflow_q;
    assign G     = g_q;
    assign E     = e_q;
    assign L     = l_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, corner sequences (CE stall,
// reset mid-multiply) and randomized traffic against an arithmetic reference model.
module tb_alu_core;

`ifdef ALU_MULT_EN
    localparam bit MULT_ON = 1'b1;
`else
    localparam bit MULT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  inp_valid = 2'b00;
    logic        mode = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic        ce = 1'b1;
    logic [7:0]  opa = 8'd0;
    logic [7:0]  opb = 8'd0;
    logic        cin = 1'b0;
    logic [16:0] res;
    logic        cout, oflow, g, e, l, err;

    int checks = 0;
    int failures = 0;

    alu_core #(.DATA_W(8), .CMD_W(4)) dut (
        .CLK(clk), .RST(rst), .INP_VALID(inp_valid), .MODE(mode), .CMD(cmd), .CE(ce),
        .OPA(opa), .OPB(opb), .CIN(cin), .RES(res), .COUT(cout), .OFLOW(oflow),
        .G(g), .E(e), .L(l), .ERR(err)
    );

    always #5 clk = ~clk;

    // Output tuple: {RES, COUT, OFLOW, G, E, L, ERR}
    logic [22:0] dut_out;
    assign dut_out = {res, cout, oflow, g, e, l, err};

    localparam logic [22:0] ERR_TUP = 23'd1;

    typedef struct {
        string      name;
        bit         mode;
        int         cmd;
        bit [1:0]   iv;
        int         a;
        int         b;
        bit         cin;
        logic [22:0] exp;
        bit         two;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [22:0] tup(input int r, input bit [5:0] fl);
        logic [16:0] rr;
        rr = 17'(r);
        return {rr, fl};
    endfunction

    function automatic vec_t mk(input string nm, input bit md, input int c, input bit [1:0] iv,
                                input int a, input int b, input bit ci, input logic [22:0] ex,
                                input bit two);
        vec_t v;
        v.name = nm; v.mode = md; v.cmd = c; v.iv = iv; v.a = a; v.b = b; v.cin = ci;
        v.exp = ex; v.two = two;
        return v;
    endfunction

    // Reference: what one accepted command yields, from the command table in plain integers.
    function automatic void ref_op(input bit md, input int c, input bit [1:0] iv, input int a,
                                   input int b, input int ci, output logic [22:0] o,
                                   output bit mul);
        int  need, r, s;
        bit  def, co, ov, gg, ee, ll;
        need = 3; def = 1; r = 0; co = 0; ov = 0; gg = 0; ee = 0; ll = 0; mul = 0;
        if (md) begin
            case (c)
                0: begin r = a + b; co = (r > 255); end
                1: begin r = a - b; ov = (a < b); end
                2: begin r = a + b + ci; co = (r > 255); end
                3: begin r = a - b - ci; ov = (a < b + ci); end
                4: begin need = 1; r = a + 1; co = (r > 255); end
                5: begin need = 1; r = a - 1; ov = (a == 0); end
                6: begin need = 2; r = b + 1; co = (r > 255); end
                7: begin need = 2; r = b - 1; ov = (b == 0); end
                8: begin gg = (a > b); ee = (a == b); ll = (a < b); end
                9: if (MULT_ON) begin mul = 1; r = ((a + 1) * (b + 1)) % 65536; end else def = 0;
                10: if (MULT_ON) begin mul = 1; r = (((a * 2) % 256) * b) % 65536; end else def = 0;
                default: def = 0;
            endcase
        end else begin
            s = b % 8;
            case (c)
                0: r = a & b;
                1: r = 255 - (a & b);
                2: r = a | b;
                3: r = 255 - (a | b);
                4: r = a ^ b;
                5: r = 255 - (a ^ b);
                6: begin need = 1; r = 255 - a; end
                7: begin need = 2; r = 255 - b; end
                8: begin need = 1; r = a / 2; end
                9: begin need = 1; r = (a * 2) % 256; end
                10: begin need = 2; r = b / 2; end
                11: begin need = 2; r = (b * 2) % 256; end
                12: if (b >= 16) def = 0; else r = ((a << s) | (a >> (8 - s))) & 255;
                13: if (b >= 16) def = 0; else r = ((a >> s) | (a << (8 - s))) & 255;
                default: def = 0;
            endcase
        end
        if (!def || ((int'(iv) & need) != need)) begin
            o = ERR_TUP;
            mul = 0;
        end else begin
            if (!mul) r = ((r % 512) + 512) % 512;
            o = tup(r, {co, ov, gg, ee, ll, 1'b0});
        end
    endfunction

    task automatic check(input string nm, input logic [22:0] act, input logic [22:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s: got RES=%h flags(c,o,g,e,l,err)=%b, expected RES=%h flags=%b",
                     nm, act[22:6], act[5:0], ex[22:6], ex[5:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit md, input int c, input bit [1:0] iv, input int a,
                         input int b, input bit ci);
        mode = md; cmd = 4'(c); inp_valid = iv; opa = 8'(a); opb = 8'(b); cin = ci;
    endtask

    logic [22:0] m_out;
    logic [22:0] pend_q[$];
    logic [22:0] prev;

    initial begin
        // Directed table
        vecs.push_back(mk("add_ff_01",   1, 0, 2'b11, 8'hFF, 8'h01, 0, tup(9'h100, 6'b100000), 0));
        vecs.push_back(mk("cmp_lt",      1, 8, 2'b11, 5, 9, 0, tup(0, 6'b000010), 0));
        vecs.push_back(mk("cmp_eq",      1, 8, 2'b11, 7, 7, 0, tup(0, 6'b000100), 0));
        vecs.push_back(mk("cmp_gt",      1, 8, 2'b11, 9, 5, 0, tup(0, 6'b001000), 0));
        vecs.push_back(mk("sub_borrow",  1, 1, 2'b11, 3, 5, 0, tup(9'h1FE, 6'b010000), 0));
        vecs.push_back(mk("subcin_brw",  1, 3, 2'b11, 5, 5, 1, tup(9'h1FF, 6'b010000), 0));
        vecs.push_back(mk("addcin_max",  1, 2, 2'b11, 8'hFF, 8'hFF, 1, tup(9'h1FF, 6'b100000), 0));
        vecs.push_back(mk("add_nocarry", 1, 0, 2'b11, 8'h7F, 8'h01, 0, tup(9'h080, 6'b000000), 0));
        vecs.push_back(mk("deca_zero",   1, 5, 2'b01, 0, 8'h33, 0, tup(9'h1FF, 6'b010000), 0));
        vecs.push_back(mk("incb_ff",     1, 6, 2'b10, 0, 8'hFF, 0, tup(9'h100, 6'b100000), 0));
        vecs.push_back(mk("rol_1",       0, 12, 2'b11, 8'h81, 1, 0, tup(8'h03, 6'b0), 0));
        vecs.push_back(mk("rol_badb",    0, 12, 2'b11, 8'h81, 8'h10, 0, ERR_TUP, 0));
        vecs.push_back(mk("ror_1",       0, 13, 2'b11, 8'h81, 1, 0, tup(8'hC0, 6'b0), 0));
        vecs.push_back(mk("rol_b8",      0, 12, 2'b11, 8'h81, 8, 0, tup(8'h81, 6'b0), 0));
        vecs.push_back(mk("nand",        0, 1, 2'b11, 8'hF0, 8'hCC, 0, tup(8'h3F, 6'b0), 0));
        vecs.push_back(mk("xnor",        0, 5, 2'b11, 8'hF0, 8'hCC, 0, tup(8'hC3, 6'b0), 0));
        vecs.push_back(mk("not_b",       0, 7, 2'b10, 0, 8'h5A, 0, tup(8'hA5, 6'b0), 0));
        vecs.push_back(mk("shl_a",       0, 9, 2'b01, 8'h81, 0, 0, tup(8'h02, 6'b0), 0));
        vecs.push_back(mk("shr_b",       0, 10, 2'b10, 0, 8'h81, 0, tup(8'h40, 6'b0), 0));
        vecs.push_back(mk("logic_undef", 0, 14, 2'b11, 1, 2, 0, ERR_TUP, 0));
        vecs.push_back(mk("arith_undef", 1, 15, 2'b11, 1, 2, 0, ERR_TUP, 0));
        vecs.push_back(mk("nota_no_a",   0, 6, 2'b10, 1, 2, 0, ERR_TUP, 0));
        vecs.push_back(mk("sub_no_a",    1, 1, 2'b10, 1, 2, 0, ERR_TUP, 0));
        vecs.push_back(mk("mul_inc_3_4", 1, 9, 2'b11, 3, 4, 0, MULT_ON ? tup(20, 6'b0) : ERR_TUP, MULT_ON));
        vecs.push_back(mk("mul_shl",     1, 10, 2'b11, 8'h81, 3, 0, MULT_ON ? tup(6, 6'b0) : ERR_TUP, MULT_ON));
        vecs.push_back(mk("mul_inc_max", 1, 9, 2'b11, 8'hFF, 8'hFF, 0, MULT_ON ? tup(0, 6'b0) : ERR_TUP, MULT_ON));

        // Reset state
        step();
        step();
        check("reset_state", dut_out, 23'd0);
        #2 rst = 1'b0;
        prev = 23'd0;

        // First vector lands on the first edge after reset release
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].cmd, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].cin);
            ce = 1'b1;
            step();
            if (vecs[i].two) begin
                check({vecs[i].name, "_hold"}, dut_out, prev);
                inp_valid = 2'b00;
                step();
            end
            check(vecs[i].name, dut_out, vecs[i].exp);
            $display("vec %-12s mode=%0d cmd=%0d iv=%b a=%h b=%h -> RES=%h flags=%b",
                     vecs[i].name, vecs[i].mode, vecs[i].cmd, vecs[i].iv, vecs[i].a[7:0],
                     vecs[i].b[7:0], res, dut_out[5:0]);
            prev = vecs[i].exp;
        end

        // Missing operand, then CE=0 freezes, then INP_VALID=00 holds
        drive(1, 0, 2'b01, 1, 2, 0);
        step();
        check("add_missing_b", dut_out, ERR_TUP);
        ce = 1'b0;
        drive(0, 0, 2'b11, 8'hFF, 8'hFF, 0);
        step();
        step();
        check("ce0_hold", dut_out, ERR_TUP);
        ce = 1'b1;
        drive(1, 0, 2'b00, 1, 1, 0);
        step();
        check("iv00_hold", dut_out, ERR_TUP);
        $display("seq ce/iv hold: RES=%h flags=%b", res, dut_out[5:0]);

        // A command issued in the multiply's second cycle is dropped
        drive(1, 9, 2'b11, 3, 4, 0);
        step();
        drive(1, 0, 2'b11, 1, 1, 0);
        step();
        check("mul_ignores_new", dut_out, MULT_ON ? tup(20, 6'b0) : tup(2, 6'b0));
        inp_valid = 2'b00;
        step();
        check("mul_no_late_add", dut_out, MULT_ON ? tup(20, 6'b0) : tup(2, 6'b0));
        $display("seq mul overlap: RES=%h flags=%b", res, dut_out[5:0]);

        // CE=0 stalls an in-flight multiply
        drive(1, 10, 2'b11, 8'h81, 3, 0);
        step();
        ce = 1'b0;
        inp_valid = 2'b00;
        step();
        step();
        check("mul_stall", dut_out, MULT_ON ? tup(20, 6'b0) : ERR_TUP);
        ce = 1'b1;
        step();
        check("mul_resume", dut_out, MULT_ON ? tup(6, 6'b0) : ERR_TUP);
        $display("seq mul stall: RES=%h flags=%b", res, dut_out[5:0]);

        // Reset pulse mid-multiply
        drive(1, 0, 2'b11, 8'hFF, 8'h01, 0);
        step();
        drive(1, 9, 2'b11, 3, 4, 0);
        step();
        check("pre_reset", dut_out, MULT_ON ? tup(9'h100, 6'b100000) : ERR_TUP);
        inp_valid = 2'b00;
        #2 rst = 1'b1;
        #1 check("reset_async", dut_out, 23'd0);
        #1 rst = 1'b0;
        step();
        step();
        step();
        check("reset_abort", dut_out, 23'd0);
        $display("seq reset mid-mul: RES=%h flags=%b", res, dut_out[5:0]);

        // Randomized traffic against the reference model
        m_out = 23'd0;
        pend_q.delete();
        for (int i = 0; i < 300; i++) begin
            logic [22:0] o;
            bit          mul;
            drive($urandom_range(0, 1), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 255),
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 255),
                  1'($urandom_range(0, 1)));
            ce = ($urandom_range(0, 4) != 0);
            @(posedge clk);
            if (ce) begin
                if (pend_q.size() > 0) begin
                    m_out = pend_q.pop_front();
                end else if (inp_valid != 2'b00) begin
                    ref_op(mode, int'(cmd), inp_valid, int'(opa), int'(opb), int'(cin), o, mul);
                    if (mul) pend_q.push_back(o);
                    else m_out = o;
                end
            end
            #1;
            check("random", dut_out, m_out);
            $display("rnd %0d ce=%b mode=%0d cmd=%0d iv=%b a=%h b=%h cin=%b -> RES=%h flags=%b",
                     i, ce, mode, cmd, inp_valid, opa, opb, cin, res, dut_out[5:0]);
            if (i % 100 == 50) begin
                #2 rst = 1'b1;
                #1 check("random_reset", dut_out, 23'd0);
                #1 rst = 1'b0;
                m_out = 23'd0;
                pend_q.delete();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
